// File: rtl/ob_arb_pkg.sv
// Shared definitions for the output-port arbiter: flit format, type codes and FSM states.
package ob_arb_pkg;

  localparam int NIN   = 4;
  localparam int IDXW  = 2;
  localparam int PKTW  = 8;
  localparam int FLITW = PKTW + 1;

  // The flit type occupies the top two bits of a flit.
  localparam int FT_HI = PKTW;
  localparam int FT_LO = PKTW - 1;

  typedef enum logic [1:0] {
    FT_IDLE = 2'b00,
    FT_HEAD = 2'b01,
    FT_BODY = 2'b10,
    FT_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    OB_IDLE = 1'b0,
    OB_BUSY = 1'b1
  } ob_state_e;

  function automatic flit_type_e flit_type(input logic [FLITW-1:0] flit);
    return flit_type_e'(flit[FT_HI:FT_LO]);
  endfunction

endpackage

// File: rtl/ob_arb_rrsel.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo NIN.
module ob_arb_rrsel #(
  parameter int NIN  = 4,
  parameter int IDXW = 2
) (
  input  logic [NIN-1:0]  req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            valid
);

  logic [IDXW-1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    // The last-served index is visited last, giving it the lowest priority.
    for (int k = 1; k <= NIN; k++) begin
      cand = IDXW'((int'(ptr) + k) % NIN);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ob_arb.sv
// Output-port arbiter: grants one input buffer per packet round-robin and forwards its
// flits through a registered output stage.
module ob_arb
  import ob_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NIN-1:0]   req,
  input  logic [FLITW-1:0] pkt0,
  input  logic [FLITW-1:0] pkt1,
  input  logic [FLITW-1:0] pkt2,
  input  logic [FLITW-1:0] pkt3,
  input  logic             full,
  output logic [NIN-1:0]   ack,
  output logic [FLITW-1:0] pkto,
  output logic             busy
);

  ob_state_e        state, next_state;
  logic [IDXW-1:0]  gnt, next_gnt;
  logic [IDXW-1:0]  ptr, next_ptr;
  logic [IDXW-1:0]  pick;
  logic             pick_valid;
  logic [FLITW-1:0] pkt_gnt;
  flit_type_e       ft;

  ob_arb_rrsel #(
    .NIN  (NIN),
    .IDXW (IDXW)
  ) u_rrsel (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick),
    .valid (pick_valid)
  );

  always_comb begin
    case (gnt)
      2'd0:    pkt_gnt = pkt0;
      2'd1:    pkt_gnt = pkt1;
      2'd2:    pkt_gnt = pkt2;
      default: pkt_gnt = pkt3;
    endcase
  end

  assign ft = flit_type(pkt_gnt);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    next_state = state;
    next_gnt   = gnt;
    next_ptr   = ptr;
    ack        = '0;
    case (state)
      OB_IDLE: begin
        if (pick_valid) begin
          next_gnt   = pick;
          next_state = OB_BUSY;
        end
      end
      OB_BUSY: begin
        // Only the tail closes the packet; a stray head is forwarded like a body.
        if (!full && ft != FT_IDLE) begin
          ack[gnt] = 1'b1;
          if (ft == FT_TAIL) begin
            next_state = OB_IDLE;
            next_ptr   = gnt;
          end
        end
      end
      default: next_state = OB_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OB_IDLE;
      gnt   <= '0;
      ptr   <= IDXW'(NIN - 1);
      pkto  <= '0;
    end else begin
      state <= next_state;
      gnt   <= next_gnt;
      ptr   <= next_ptr;
      pkto  <= (|ack) ? pkt_gnt : '0;
    end
  end

  assign busy = (state == OB_BUSY);

endmodule

// File: tb/tb_ob_arb.sv
// Directed, table-driven bench for ob_arb: one vector per clock cycle plus an async-reset sequence.
module tb_ob_arb;
  import ob_arb_pkg::*;

  typedef struct {
    logic [3:0] req;
    logic [8:0] p0, p1, p2, p3;
    logic       full;
    logic [3:0] ack;
    logic       busy;
    logic [8:0] pkto;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NIN-1:0]   req = '0;
  logic [FLITW-1:0] pkt0 = '0, pkt1 = '0, pkt2 = '0, pkt3 = '0;
  logic             full = 1'b0;
  logic [NIN-1:0]   ack;
  logic [FLITW-1:0] pkto;
  logic             busy;

  int checks = 0;
  int errors = 0;

  vec_t tbl[$];

  ob_arb dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .pkt0 (pkt0),
    .pkt1 (pkt1),
    .pkt2 (pkt2),
    .pkt3 (pkt3),
    .full (full),
    .ack  (ack),
    .pkto (pkto),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] fl(input logic [1:0] t, input logic [6:0] d);
    return {t, d};
  endfunction

  function automatic vec_t v(input logic [3:0] rq, input logic [8:0] a, b, c, d,
                             input logic fu, input logic [3:0] ek, input logic eb,
                             input logic [8:0] ep);
    vec_t r;
    r.req = rq; r.p0 = a; r.p1 = b; r.p2 = c; r.p3 = d; r.full = fu;
    r.ack = ek; r.busy = eb; r.pkto = ep;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t x, input int n);
    @(negedge clk);
    req = x.req; pkt0 = x.p0; pkt1 = x.p1; pkt2 = x.p2; pkt3 = x.p3; full = x.full;
    #1;
    check($sformatf("v%0d ack", n),  32'(ack),  32'(x.ack));
    check($sformatf("v%0d busy", n), 32'(busy), 32'(x.busy));
    check($sformatf("v%0d pkto", n), 32'(pkto), 32'(x.pkto));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] a0, a1, a2, a3, c0, c1;
    logic [8:0] h1, b1, b2, he, t1, h40, b41, h50, t51, h52, t53, h60;
    a0 = fl(2'b01, 7'h10); a1 = fl(2'b11, 7'h11);
    a2 = fl(2'b01, 7'h12); a3 = fl(2'b11, 7'h13);
    c0 = fl(2'b01, 7'h20); c1 = fl(2'b11, 7'h21);
    h1 = fl(2'b01, 7'h31); b1 = fl(2'b10, 7'h32); b2 = fl(2'b10, 7'h33);
    he = fl(2'b01, 7'h35); t1 = fl(2'b11, 7'h34);
    h40 = fl(2'b01, 7'h40); b41 = fl(2'b10, 7'h41);
    h50 = fl(2'b01, 7'h50); t51 = fl(2'b11, 7'h51);
    h52 = fl(2'b01, 7'h52); t53 = fl(2'b11, 7'h53);
    h60 = fl(2'b01, 7'h60);

    // Contention from reset (ptr=3): input 0, then 2 despite req[0], then 0 again.
    tbl.push_back(v(4'b0101, a0, 0, c0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(v(4'b0101, a0, 0, c0, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(v(4'b0101, a1, 0, c0, 0, 0, 4'b0001, 1, a0));
    tbl.push_back(v(4'b0101, a2, 0, c0, 0, 0, 4'b0000, 0, a1));
    tbl.push_back(v(4'b0101, a2, 0, c0, 0, 0, 4'b0100, 1, 0));
    tbl.push_back(v(4'b0101, a2, 0, c1, 0, 0, 4'b0100, 1, c0));
    tbl.push_back(v(4'b0001, a2, 0, 0,  0, 0, 4'b0000, 0, c1));
    tbl.push_back(v(4'b0001, a2, 0, 0,  0, 0, 4'b0001, 1, 0));
    tbl.push_back(v(4'b0001, a3, 0, 0,  0, 0, 4'b0001, 1, a2));
    tbl.push_back(v(4'b0000, 0,  0, 0,  0, 0, 4'b0000, 0, a3));
    // Input 1 packet with a 3-cycle gap, 2 cycles of full, and a stray head.
    tbl.push_back(v(4'b0010, 0, h1, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(v(4'b0010, 0, h1, 0, 0, 0, 4'b0010, 1, 0));
    tbl.push_back(v(4'b0000, 0, 0,  0, 0, 0, 4'b0000, 1, h1));
    tbl.push_back(v(4'b0000, 0, 0,  0, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(v(4'b0000, 0, 0,  0, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(v(4'b0010, 0, b1, 0, 0, 0, 4'b0010, 1, 0));
    tbl.push_back(v(4'b0010, 0, b2, 0, 0, 1, 4'b0000, 1, b1));
    tbl.push_back(v(4'b1011, h40, b2, 0, h50, 1, 4'b0000, 1, 0));
    tbl.push_back(v(4'b1011, h40, b2, 0, h50, 0, 4'b0010, 1, 0));
    tbl.push_back(v(4'b1011, h40, he, 0, h50, 0, 4'b0010, 1, b2));
    tbl.push_back(v(4'b1011, h40, t1, 0, h50, 0, 4'b0010, 1, he));
    // ptr=1 now: search 2,3 picks input 3 ahead of input 0.
    tbl.push_back(v(4'b1001, h40, 0, 0, h50, 0, 4'b0000, 0, t1));
    tbl.push_back(v(4'b1001, h40, 0, 0, h50, 0, 4'b1000, 1, 0));
    tbl.push_back(v(4'b1001, h40, 0, 0, t51, 0, 4'b1000, 1, h50));
    // Wrap-around: ptr=3, only req[3] -> input 3 again, ptr stays 3.
    tbl.push_back(v(4'b1000, 0, 0, 0, h52, 0, 4'b0000, 0, t51));
    tbl.push_back(v(4'b1000, 0, 0, 0, h52, 0, 4'b1000, 1, 0));
    tbl.push_back(v(4'b1000, 0, 0, 0, t53, 0, 4'b1000, 1, h52));
    // ptr=3 confirmed by input 0 being first in the search.
    tbl.push_back(v(4'b0001, h40, 0, 0, 0, 0, 4'b0000, 0, t53));
    tbl.push_back(v(4'b0001, h40, 0, 0, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(v(4'b0001, b41, 0, 0, 0, 0, 4'b0001, 1, h40));

    // Reset state.
    @(negedge clk);
    #1;
    check("reset ack",  32'(ack),  32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset pkto", 32'(pkto), 32'h0);
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i], i);

    // Async reset mid-packet, between clock edges.
    @(negedge clk);
    #1;
    check("pre-reset pkto", 32'(pkto), 32'(b41));
    check("pre-reset busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("async pkto", 32'(pkto), 32'h0);
    check("async ack",  32'(ack),  32'h0);
    check("async busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0; req = 4'b0010; pkt0 = '0; pkt1 = h60;
    #1;
    check("post-reset busy", 32'(busy), 32'h0);
    check("post-reset ack",  32'(ack),  32'h0);
    @(negedge clk);
    #1;
    check("regrant busy", 32'(busy), 32'h1);
    check("regrant ack",  32'(ack),  32'b0010);
    @(negedge clk);
    #1;
    check("regrant pkto", 32'(pkto), 32'(h60));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
